// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions: receiver state encodings, baud constants, vote helper
package uart_pkg;

  localparam int FAST_BIT = 50;
  localparam int SLOW_BIT = 219;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_GAP,
    RX_BREAK
  } rx_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - rx synchroniser, falling-edge detect and 3-sample majority voter
module uart_rx_sampler
  import uart_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic rx_i,
  input  logic smp0_i,
  input  logic smp1_i,
  input  logic dec_i,
  output logic rx_s_o,
  output logic fall_o,
  output logic bit_val_o,
  output logic bit_stb_o
);

  logic meta_q, sync_q, prev_q, s0_q, s1_q;

  // Everything resets to the idle-line level so no edge is seen after reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
      s0_q   <= 1'b1;
      s1_q   <= 1'b1;
    end else begin
      meta_q <= rx_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
      if (smp0_i) s0_q <= sync_q;
      if (smp1_i) s1_q <= sync_q;
    end
  end

  assign rx_s_o    = sync_q;
  assign fall_o    = prev_q & ~sync_q;
  assign bit_val_o = maj3(s0_q, s1_q, sync_q);
  assign bit_stb_o = dec_i;

endmodule

// File: rtl/uart_rx16.sv
// rtl/uart_rx16.sv - UART receiver assembling 16-bit words from two bytes, low byte first
module uart_rx16
  import uart_pkg::*;
#(
  parameter int BIT_CYCLES   = FAST_BIT,
  parameter int TIMEOUT_BITS = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx,
  output logic [15:0] DATA,
  output logic        VALID,
  output logic        frame_err,
  output logic        timeout_err,
  output logic        busy
);

  localparam int LIMIT = TIMEOUT_BITS * BIT_CYCLES;
  localparam int CW    = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] SMP0    = CW'(BIT_CYCLES / 2 - 1);
  localparam logic [CW-1:0] SMP1    = CW'(BIT_CYCLES / 2);
  localparam logic [CW-1:0] SMP2    = CW'(BIT_CYCLES / 2 + 1);
  localparam logic [CW-1:0] LAST    = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] GAP_MAX = CW'(LIMIT);

  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, gap_q, gap_d, gap_inc;
  logic [2:0]    bitn_q, bitn_d;
  logic [7:0]    sr_q, sr_d, lo_q, lo_d;
  logic [15:0]   data_q, data_d;
  logic          byte_idx_q, byte_idx_d;
  logic          valid_q, valid_d, ferr_q, ferr_d, terr_q, terr_d, busy_q, busy_d;
  logic          rx_s, fall, bit_val, bit_stb, in_frame, gap_hit;

  assign in_frame = state_q inside {RX_START, RX_DATA, RX_STOP};
  assign gap_inc  = (gap_q == GAP_MAX) ? gap_q : gap_q + 1'b1;
  assign gap_hit  = (state_q == RX_GAP) && (gap_inc == GAP_MAX);

  uart_rx_sampler u_sampler (
    .clock     (clock),
    .reset     (reset),
    .rx_i      (rx),
    .smp0_i    (in_frame && cnt_q == SMP0),
    .smp1_i    (in_frame && cnt_q == SMP1),
    .dec_i     (in_frame && cnt_q == SMP2),
    .rx_s_o    (rx_s),
    .fall_o    (fall),
    .bit_val_o (bit_val),
    .bit_stb_o (bit_stb)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= RX_IDLE;
      cnt_q      <= '0;
      gap_q      <= '0;
      bitn_q     <= '0;
      sr_q       <= '0;
      lo_q       <= '0;
      data_q     <= '0;
      byte_idx_q <= 1'b0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      terr_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gap_q      <= gap_d;
      bitn_q     <= bitn_d;
      sr_q       <= sr_d;
      lo_q       <= lo_d;
      data_q     <= data_d;
      byte_idx_q <= byte_idx_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      terr_q     <= terr_d;
      busy_q     <= busy_d;
    end
  end

  // STOP leaves right after its decision so a following start edge is never missed
  always_comb begin
    state_d = state_q;
    case (state_q)
      RX_IDLE:  if (fall) state_d = RX_START;
      RX_START: if (bit_stb) state_d = bit_val ? RX_IDLE : RX_DATA;
      RX_DATA:  if (bit_stb && bitn_q == 3'd7) state_d = RX_STOP;
      RX_STOP:  if (bit_stb) state_d = !bit_val ? RX_BREAK : (byte_idx_q ? RX_IDLE : RX_GAP);
      RX_GAP:   if (gap_hit) state_d = RX_IDLE; else if (fall) state_d = RX_START;
      RX_BREAK: if (rx_s) state_d = RX_IDLE;
      default:  state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    cnt_d      = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    gap_d      = gap_q;
    bitn_d     = bitn_q;
    sr_d       = sr_q;
    lo_d       = lo_q;
    data_d     = data_q;
    byte_idx_d = byte_idx_q;
    valid_d    = 1'b0;
    ferr_d     = 1'b0;
    terr_d     = 1'b0;
    busy_d     = busy_q;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (fall) begin
          busy_d     = 1'b1;
          byte_idx_d = 1'b0;
        end
      end
      RX_START: if (bit_stb) begin
        bitn_d = '0;
        if (bit_val) busy_d = 1'b0;
      end
      RX_DATA: if (bit_stb) begin
        sr_d   = {bit_val, sr_q[7:1]};
        bitn_d = bitn_q + 3'd1;
      end
      RX_STOP: if (bit_stb) begin
        if (!bit_val) begin
          ferr_d     = 1'b1;
          byte_idx_d = 1'b0;
        end else if (!byte_idx_q) begin
          lo_d  = sr_q;
          gap_d = '0;
        end else begin
          data_d  = {sr_q, lo_q};
          valid_d = 1'b1;
          busy_d  = 1'b0;
        end
      end
      // Timeout is checked before the edge so a simultaneous edge is dropped
      RX_GAP: begin
        cnt_d = '0;
        gap_d = gap_inc;
        if (gap_hit) begin
          terr_d = 1'b1;
          busy_d = 1'b0;
        end else if (fall) begin
          byte_idx_d = 1'b1;
        end
      end
      RX_BREAK: begin
        cnt_d = '0;
        if (rx_s) busy_d = 1'b0;
      end
      default: cnt_d = '0;
    endcase
  end

  assign DATA        = data_q;
  assign VALID       = valid_q;
  assign frame_err   = ferr_q;
  assign timeout_err = terr_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_uart_rx16.sv
// tb/tb_uart_rx16.sv - self-checking bench for uart_rx16 with a word-level reference model
module tb_uart_rx16;

  localparam int B     = 50;
  localparam int HALF  = B / 2;
  localparam int LIMIT = 4 * B;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        rx    = 1'b1;
  logic [15:0] data;
  logic        valid, ferr, terr, busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_valid  = 0;
  int n_ferr   = 0;
  int n_terr   = 0;
  int valid_cyc = 0;
  int terr_cyc  = 0;
  int last_stop = 0;
  logic [15:0] got_q[$];
  logic [15:0] exp_q[$];

  uart_rx16 #(.BIT_CYCLES(B), .TIMEOUT_BITS(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .rx          (rx),
    .DATA        (data),
    .VALID       (valid),
    .frame_err   (ferr),
    .timeout_err (terr),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (!reset) begin
      if (valid) begin
        n_valid   <= n_valid + 1;
        valid_cyc <= cyc;
        got_q.push_back(data);
      end
      if (ferr) n_ferr <= n_ferr + 1;
      if (terr) begin
        n_terr   <= n_terr + 1;
        terr_cyc <= cyc;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    wait_cycles(n);
  endtask

  // spike_bit >= 0 puts a 1-cycle low pulse at mid-bit of that data bit
  task automatic send_byte(input logic [7:0] b, input logic stop_v, input int stop_bits,
                           input int spike_bit);
    rx = 1'b0;
    wait_cycles(B);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      if (i == spike_bit) begin
        wait_cycles(HALF + 1);
        rx = 1'b0;
        wait_cycles(1);
        rx = b[i];
        wait_cycles(B - HALF - 2);
      end else begin
        wait_cycles(B);
      end
    end
    last_stop = cyc;
    rx = stop_v;
    wait_cycles(B * stop_bits);
    rx = 1'b1;
  endtask

  task automatic send_word(input logic [15:0] w, input int gap, input int stop_bits);
    send_byte(w[7:0], 1'b1, stop_bits, -1);
    idle(gap);
    send_byte(w[15:8], 1'b1, stop_bits, -1);
  endtask

  typedef struct {
    logic [7:0]  lo;
    logic [7:0]  hi;
    int          lo_stop;
    int          gap;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[5];
  int v0, f0, t0;
  logic [15:0] w;

  initial begin
    tbl[0] = '{8'hA5, 8'h5A, 2, 0,   16'h5AA5};
    tbl[1] = '{8'h00, 8'hFF, 1, 0,   16'hFF00};
    tbl[2] = '{8'hFF, 8'h00, 1, 37,  16'h00FF};
    tbl[3] = '{8'h34, 8'h12, 2, 120, 16'h1234};
    tbl[4] = '{8'h80, 8'h01, 1, 5,   16'h0180};

    wait_cycles(3);
    check("reset_data", 32'(data), 32'h0);
    check("reset_valid", 32'(valid), 32'h0);
    check("reset_ferr", 32'(ferr), 32'h0);
    check("reset_terr", 32'(terr), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    idle(10);

    for (int i = 0; i < 5; i++) begin
      v0 = n_valid; f0 = n_ferr; t0 = n_terr;
      send_byte(tbl[i].lo, 1'b1, tbl[i].lo_stop, -1);
      idle(tbl[i].gap);
      send_byte(tbl[i].hi, 1'b1, 2, -1);
      if (i == 0) check("valid_latency", 32'(valid_cyc), 32'(last_stop + HALF + 5));
      check("tbl_valid_count", 32'(n_valid - v0), 32'd1);
      check("tbl_data", 32'(data), 32'(tbl[i].exp));
      check("tbl_no_err", 32'((n_ferr - f0) + (n_terr - t0)), 32'd0);
    end

    got_q.delete();
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      w = 16'($urandom);
      exp_q.push_back({w[15:8], w[7:0]});
      send_word(w, $urandom_range(0, 100), $urandom_range(1, 2));
    end
    idle(5);
    check("rand_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < 8; i++) begin
      if (i < got_q.size()) check("rand_data", 32'(got_q[i]), 32'(exp_q[i]));
      else check("rand_missing", 32'(i), 32'(got_q.size() + 100));
    end

    v0 = n_valid; f0 = n_ferr; t0 = n_terr;
    begin
      int e0;
      e0 = cyc;
      rx = 1'b0;
      wait_cycles(10);
      rx = 1'b1;
      wait_cycles(2);
      check("glitch_busy_high", 32'(busy), 32'd1);
      wait_cycles(e0 + HALF + 5 - cyc);
      check("glitch_busy_low", 32'(busy), 32'd0);
    end
    idle(2 * B);
    check("glitch_no_valid", 32'(n_valid - v0), 32'd0);
    check("glitch_no_err", 32'((n_ferr - f0) + (n_terr - t0)), 32'd0);

    v0 = n_valid; f0 = n_ferr;
    send_byte(8'h33, 1'b0, 1, -1);
    idle(2 * B);
    check("ferr_count", 32'(n_ferr - f0), 32'd1);
    check("ferr_busy_low", 32'(busy), 32'd0);
    check("ferr_no_valid", 32'(n_valid - v0), 32'd0);
    send_word(16'h1234, 0, 2);
    check("ferr_then_valid", 32'(n_valid - v0), 32'd1);
    check("ferr_then_data", 32'(data), 32'h1234);

    v0 = n_valid; t0 = n_terr;
    send_byte(8'h77, 1'b1, 1, -1);
    idle(250);
    check("timeout_count", 32'(n_terr - t0), 32'd1);
    check("timeout_time", 32'(terr_cyc), 32'(last_stop + HALF + 5 + LIMIT));
    check("timeout_busy_low", 32'(busy), 32'd0);
    check("timeout_no_valid", 32'(n_valid - v0), 32'd0);
    send_word(16'h0201, 0, 2);
    check("after_timeout_data", 32'(data), 32'h0201);
    check("after_timeout_valid", 32'(n_valid - v0), 32'd1);

    v0 = n_valid;
    send_byte(8'hFF, 1'b1, 1, 0);
    send_byte(8'h81, 1'b1, 2, 7);
    check("spike_valid", 32'(n_valid - v0), 32'd1);
    check("spike_data", 32'(data), 32'h81FF);

    v0 = n_valid;
    send_byte(8'h11, 1'b1, 1, -1);
    rx = 1'b0;
    wait_cycles(B);
    rx = 1'b1;
    wait_cycles(3 * B);
    reset = 1'b1;
    #2;
    check("midrst_data", 32'(data), 32'h0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_valid", 32'(valid), 32'd0);
    check("midrst_errs", 32'({ferr, terr}), 32'd0);
    wait_cycles(3);
    reset = 1'b0;
    idle(2 * B);
    check("midrst_no_valid", 32'(n_valid - v0), 32'd0);
    send_word(16'hBEEF, 0, 2);
    check("beef_valid", 32'(n_valid - v0), 32'd1);
    check("beef_data", 32'(data), 32'hBEEF);

    v0 = n_valid;
    send_word(16'hC001, 0, 1);
    send_word(16'h0FF0, 0, 1);
    send_word(16'h9E37, 0, 1);
    idle(5);
    check("b2b_valid_count", 32'(n_valid - v0), 32'd3);
    check("b2b_last_data", 32'(data), 32'h9E37);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
